alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised, multi-cycle successor to the combinational integer ALU. Executes the RV32I/RV64I register-register ALU ops plus the M-extension multiply/divide/remainder ops.
- Operands enter through a valid/ready handshake. Results leave through a valid/ready output register.
- Sits in the execute stage. The pipeline stalls on in_ready low.
- One operation is in flight at a time.

Parameters:
- XLEN, 32, operand/result width; legal values are 32 and 64.
- SHAMT_W, $clog2(XLEN), number of low bits of b used as the shift amount (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an op this cycle.
- op  input  5  operation code, see Behaviour.
- a  input  XLEN  operand rs1.
- b  input  XLEN  operand rs2.
- kill  input  1  abort the in-flight op (pipeline flush).
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  XLEN  result value.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: result 0, single-cycle.
- Reset (rst=1 at an edge):
  - state=IDLE, out_valid=0, result=0, in_ready=0 during the reset cycle.
  - Applies mid-operation: the in-flight op is discarded and no result is produced.
- States:
  - IDLE: accept an op.
  - MUL: product computed.
  - DIV: iterating.
  - HOLD: result waiting.
- in_ready:
  - Equals (state==IDLE) && !rst.
  - Accept happens at an edge with in_valid && in_ready, call it edge k.
- Latency from accept at edge k:
  - ALU ops, and divide by zero or overflow: result registered at k+1. state→HOLD.
  - MUL*: IDLE→MUL at k. Full 2·XLEN product registered at k+1. Selected half to result at k+2. →HOLD.
  - DIV/REM (normal case): radix-2 restoring divide over |a|, |b|, one quotient bit per cycle, XLEN cycles. Sign fix-up and result load on the final iteration edge. out_valid at k+XLEN.
- HOLD:
  - out_valid=1; result stable while out_ready=0.
  - Handshake at an edge with out_valid && out_ready: out_valid←0, →IDLE.
  - No accept in the same cycle, because in_ready=0 in HOLD.
- kill:
  - Effective in MUL or DIV: →IDLE next edge, no result produced.
  - Ignored in IDLE and HOLD.
  - rst has priority over kill.
- Arithmetic (all mod 2^XLEN):
  - Shifts use b[SHAMT_W-1:0] only.
  - SLT/SLTU: result is zero-extended 0 or 1.
  - SRA: arithmetic shift of signed a.
  - MUL: low XLEN bits of the product.
  - MULH: high XLEN bits, signed×signed.
  - MULHSU: high XLEN bits, signed a × unsigned b.
  - MULHU: high XLEN bits, unsigned×unsigned.
  - DIV/REM: truncate toward zero; remainder takes the sign of a.
- Boundary cases:
  - b==0: DIV/DIVU → all ones; REM/REMU → a.
  - DIV/REM with a==MIN_INT and b==−1: quotient MIN_INT, remainder 0.
  - Inputs are sampled only at accept. a, b and op may change afterwards without effect.

Test Plan:
- XLEN=32, reset mid-DIV:
  - DIVU a=100 b=7 accepted, rst asserted 5 cycles later → out_valid stays 0 and in_ready=1 the cycle after rst falls.
  - Then ADD 0xFFFFFFFF+1 → result 0x0 at k+1.
- Shift masking and signed ops:
  - SLL a=1 b=33 → 0x2.
  - SRA a=0x80000000 b=4 → 0xF8000000.
  - SLT a=0xFFFFFFFF b=0 → 1.
  - SLTU with the same operands → 0.
- Multiply halves, each out_valid exactly at k+2:
  - MULH a=0x80000000 b=0x80000000 → 0x40000000.
  - MULHSU a=0xFFFFFFFF b=0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU a=0xFFFFFFFF b=0xFFFFFFFF → 0xFFFFFFFE.
  - MUL a=0xFFFFFFFF b=0xFFFFFFFF → 0x1.
- Divide timing and signs:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - Both produce out_valid at k+32.
- Divide special cases, result at k+1:
  - DIV x/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Backpressure and kill:
  - out_ready=0 for 10 cycles → result stable, in_ready=0; on out_ready=1 result consumed, next op accepted the following cycle.
  - kill during MUL → no out_valid.
  - XLEN=64 build: MULHU of two all-ones 64-bit operands → 0xFFFFFFFFFFFFFFFE, out_valid at k+2.

Source files
------------

// File: rtl/alu_mdu.sv
// Multi-cycle integer ALU with RV M-extension multiply/divide.
// One op in flight; operands are captured at accept and the result is held until consumed.
// Single-cycle ops (ALU ops, unknown codes, divide by zero/overflow) pass one cycle through
// StMul with the phase bit preset, so kill and timing behave uniformly.
module alu_mdu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StHold} state_e;

  state_e              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic                ph_q, ph_d;
  logic [XLEN-1:0]     quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Accept-time decode of the incoming op.
  logic is_mul_in, is_div_in, div_sgn_in, a_neg_in, b_neg_in, div_special_in;
  assign is_mul_in      = (op[4:2] == 3'b100);
  assign is_div_in      = (op[4:2] == 3'b101);
  assign div_sgn_in     = ~op[0];
  assign a_neg_in       = div_sgn_in & a[XLEN-1];
  assign b_neg_in       = div_sgn_in & b[XLEN-1];
  assign div_special_in = (b == '0) ||
                          (div_sgn_in && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}}));

  // Full-width product from latched operands; sign-extend per op before a 2*XLEN multiply.
  logic              ma_sgn, mb_sgn;
  logic [2*XLEN-1:0] ma, mb, prod_full;
  assign ma_sgn    = (op_q == 5'd17) || (op_q == 5'd18);
  assign mb_sgn    = (op_q == 5'd17);
  assign ma        = {{XLEN{ma_sgn & a_q[XLEN-1]}}, a_q};
  assign mb        = {{XLEN{mb_sgn & b_q[XLEN-1]}}, b_q};
  assign prod_full = ma * mb;

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0]   r_sh, r_diff;
  logic            q_bit;
  logic [XLEN-1:0] r_next, q_next, quo_fix, rem_fix;
  assign r_sh    = {rem_q, quo_q[XLEN-1]};
  assign r_diff  = r_sh - {1'b0, dsr_q};
  assign q_bit   = ~r_diff[XLEN];
  assign r_next  = q_bit ? r_diff[XLEN-1:0] : r_sh[XLEN-1:0];
  assign q_next  = {quo_q[XLEN-2:0], q_bit};
  assign quo_fix = q_neg_q ? -q_next : q_next;
  assign rem_fix = r_neg_q ? -r_next : r_next;

  // Result select for everything that finishes through StMul.
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    exec_res;
  assign shamt = b_q[SHAMT_W-1:0];
  always_comb begin
    exec_res = '0;
    case (op_q)
      5'd0:    exec_res = a_q + b_q;
      5'd1:    exec_res = a_q - b_q;
      5'd2:    exec_res = a_q << shamt;
      5'd3:    exec_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      5'd4:    exec_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      5'd5:    exec_res = a_q ^ b_q;
      5'd6:    exec_res = a_q >> shamt;
      5'd7:    exec_res = $unsigned($signed(a_q) >>> shamt);
      5'd8:    exec_res = a_q | b_q;
      5'd9:    exec_res = a_q & b_q;
      5'd16:   exec_res = prod_q[XLEN-1:0];
      5'd17, 5'd18, 5'd19: exec_res = prod_q[2*XLEN-1:XLEN];
      // Only divide-by-zero and signed overflow reach here.
      5'd20, 5'd21, 5'd22, 5'd23: begin
        if (b_q == '0) exec_res = op_q[1] ? a_q : {XLEN{1'b1}};
        else           exec_res = op_q[1] ? '0  : a_q;
      end
      default: exec_res = '0;
    endcase
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    ph_d     = ph_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (is_div_in && !div_special_in) begin
            state_d = StDiv;
            quo_d   = a_neg_in ? -a : a;
            dsr_d   = b_neg_in ? -b : b;
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = a_neg_in ^ b_neg_in;
            r_neg_d = a_neg_in;
          end else begin
            state_d = StMul;
            ph_d    = ~is_mul_in;
          end
        end
      end
      StMul: begin
        if (kill) begin
          state_d = StIdle;
        end else if (!ph_q) begin
          prod_d = prod_full;
          ph_d   = 1'b1;
        end else begin
          result_d = exec_res;
          state_d  = StHold;
        end
      end
      StDiv: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          quo_d = q_next;
          rem_d = r_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHAMT_W'(XLEN - 1)) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      ph_q     <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      ph_q     <= ph_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StHold);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: 32-bit instance for most scenarios, 64-bit instance for MULHU.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, kill, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] a, b, result;

  logic        in_valid64, in_ready64, kill64, out_valid64, out_ready64;
  logic [4:0]  op64;
  logic [63:0] a64, b64, result64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  alu_mdu #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .op(op64), .a(a64),
    .b(b64), .kill(kill64), .out_valid(out_valid64), .out_ready(out_ready64),
    .result(result64)
  );

  // Issue one op, scramble inputs right after accept, return cycles from accept to out_valid.
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] res);
    int g = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'd9; a = 32'h5A5A5A5A; b = 32'hA5A5A5A5;
    lat = -1; res = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; res = result; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b result=%h in_ready=%b, want 0 0 0",
               out_valid, result, in_ready);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat; logic [31:0] res; logic seen = 1'b0;
    @(negedge clk);
    op = 5'd21; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_div_reset_cycle: in_ready=%b out_valid=%b want 0 0",
                      in_ready, out_valid);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_div_ready_after: in_ready=%b want 1", in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL mid_div_no_result: out_valid seen=%b want 0", seen);
    end
    run_op(5'd0, 32'hFFFFFFFF, 32'h1, lat, res);
    total++;
    if (res !== 32'h0 || lat !== 1) begin
      bad++; $display("FAIL add_after_reset: result=%h lat=%0d want 0 lat 1", res, lat);
    end
  endtask

  task automatic test_alu();
    logic [4:0]  ops [8] = '{5'd2, 5'd7, 5'd3, 5'd4, 5'd1, 5'd5, 5'd6, 5'd10};
    logic [31:0] av  [8] = '{32'h1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd5, 32'hF0F0F0F0, 32'h80000000, 32'h1234};
    logic [31:0] bv  [8] = '{32'd33, 32'd4, 32'h0, 32'h0,
                             32'd7, 32'hFF00FF00, 32'd36, 32'h5678};
    logic [31:0] ev  [8] = '{32'h2, 32'hF8000000, 32'h1, 32'h0,
                             32'hFFFFFFFE, 32'h0FF00FF0, 32'h08000000, 32'h0};
    int lat; logic [31:0] res;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], av[i], bv[i], lat, res);
      total++;
      if (res !== ev[i] || lat !== 1) begin
        bad++; $display("FAIL alu op%0d: result=%h lat=%0d want %h lat 1",
                        ops[i], res, lat, ev[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [4] = '{5'd17, 5'd18, 5'd19, 5'd16};
    logic [31:0] av  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev  [4] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], lat, res);
      total++;
      if (res !== ev[i] || lat !== 2) begin
        bad++; $display("FAIL mul op%0d: result=%h lat=%0d want %h lat 2",
                        ops[i], res, lat, ev[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [4] = '{5'd20, 5'd22, 5'd21, 5'd23};
    logic [31:0] av  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], lat, res);
      total++;
      if (res !== ev[i] || lat !== 32) begin
        bad++; $display("FAIL div op%0d: result=%h lat=%0d want %h lat 32",
                        ops[i], res, lat, ev[i]);
      end
    end
  endtask

  task automatic test_div_special();
    logic [4:0]  ops [4] = '{5'd20, 5'd23, 5'd20, 5'd22};
    logic [31:0] av  [4] = '{32'd1234, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bv  [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev  [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], lat, res);
      total++;
      if (res !== ev[i] || lat !== 1) begin
        bad++; $display("FAIL div_special op%0d: result=%h lat=%0d want %h lat 1",
                        ops[i], res, lat, ev[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res; int hold_bad = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(5'd0, 32'd3, 32'd4, lat, res);
    total++;
    if (res !== 32'd7 || lat !== 1) begin
      bad++; $display("FAIL bp_first: result=%h lat=%0d want 7 lat 1", res, lat);
    end
    @(negedge clk);
    op = 5'd1; a = 32'd10; b = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) hold_bad++;
    end
    total++;
    if (hold_bad !== 0) begin
      bad++; $display("FAIL bp_hold: bad hold cycles=%0d want 0", hold_bad);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_consume: out_valid=%b in_ready=%b want 0 1",
                      out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd7) begin
      bad++; $display("FAIL bp_next_op: out_valid=%b result=%h want 1 00000007",
                      out_valid, result);
    end
  endtask

  task automatic test_kill();
    int lat; logic [31:0] res; logic seen = 1'b0; int g = 0;
    @(negedge clk);
    op = 5'd19; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL kill_mul: out_valid seen=%b in_ready=%b want 0 1", seen, in_ready);
    end
    // kill while a result is held must not drop it
    out_ready = 1'b0;
    run_op(5'd8, 32'hF0, 32'h0F, lat, res);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'hFF) begin
      bad++; $display("FAIL kill_hold: out_valid=%b result=%h want 1 000000ff",
                      out_valid, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res;
    run_op(5'd9, 32'hFF00FF00, 32'h0FF00FF0, lat, res);
    total++;
    if (res !== 32'h0F000F00 || lat !== 1) begin
      bad++; $display("FAIL b2b_and: result=%h lat=%0d want 0f000f00 lat 1", res, lat);
    end
    run_op(5'd16, 32'd1000, 32'd1000, lat, res);
    total++;
    if (res !== 32'd1000000 || lat !== 2) begin
      bad++; $display("FAIL b2b_mul: result=%h lat=%0d want 000f4240 lat 2", res, lat);
    end
    run_op(5'd22, 32'd17, 32'hFFFFFFFB, lat, res);
    total++;
    if (res !== 32'd2 || lat !== 32) begin
      bad++; $display("FAIL b2b_rem: result=%h lat=%0d want 2 lat 32", res, lat);
    end
  endtask

  task automatic test_mul64();
    int lat = -1; int g = 0;
    @(negedge clk);
    op64 = 5'd19; a64 = '1; b64 = '1; in_valid64 = 1'b1;
    while (!in_ready64 && g < 100) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid64 = 1'b0; a64 = '0; b64 = '0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (out_valid64) begin lat = n; break; end
    end
    total++;
    if (result64 !== 64'hFFFFFFFFFFFFFFFE || lat !== 2) begin
      bad++; $display("FAIL mulhu64: result=%h lat=%0d want fffffffffffffffe lat 2",
                      result64, lat);
    end
  endtask

  initial begin
    in_valid = 1'b0; op = '0; a = '0; b = '0; kill = 1'b0; out_ready = 1'b1;
    in_valid64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; kill64 = 1'b0; out_ready64 = 1'b1;
    test_reset();
    test_reset_mid_div();
    test_alu();
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_kill();
    test_back_to_back();
    test_mul64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
